// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit carry chain split into STAGES slices, one per rank.
// Define ADDER_SAT_EN to clamp the result to signed max/min on overflow.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned W_S  = WIDTH / STAGES;
    localparam int unsigned WS1  = W_S + 1;
    localparam int unsigned LAST = STAGES - 1;

    logic             adv_c;
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_s   [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [W_S:0]     slice_c [STAGES];
    logic [WIDTH-1:0] s_d     [STAGES];
    logic [STAGES-1:0] cy_d;
    logic [WIDTH-1:0] raw_c;
    logic [WIDTH-1:0] res_c;
    logic             msb_cin_c;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic             out_vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Whole pipeline moves together; only a stalled valid result freezes it.
    assign adv_c    = !out_vld_q || out_ready;
    assign in_ready = adv_c;

    generate
        if (STAGES > 1) begin : g_mid
            logic [STAGES-2:0] vld_q;
            logic [STAGES-2:0] cy_q;
            logic [WIDTH-1:0]  a_q [STAGES-1];
            logic [WIDTH-1:0]  b_q [STAGES-1];
            logic [WIDTH-1:0]  s_q [STAGES-1];

            // Rank 0 takes the handshake inputs; subtraction folds into inverted B and carry.
            always_comb begin
                src_v[0] = in_valid;
                src_a[0] = a;
                src_b[0] = sub ? ~b : b;
                src_c[0] = sub ? ~cin : cin;
                src_s[0] = '0;
                for (int unsigned k = 1; k < STAGES; k++) begin
                    src_v[k] = vld_q[k-1];
                    src_a[k] = a_q[k-1];
                    src_b[k] = b_q[k-1];
                    src_c[k] = cy_q[k-1];
                    src_s[k] = s_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    cy_q  <= '0;
                    for (int unsigned k = 0; k < LAST; k++) begin
                        a_q[k] <= '0;
                        b_q[k] <= '0;
                        s_q[k] <= '0;
                    end
                end else if (adv_c) begin
                    for (int unsigned k = 0; k < LAST; k++) begin
                        vld_q[k] <= src_v[k];
                        cy_q[k]  <= cy_d[k];
                        a_q[k]   <= src_a[k];
                        b_q[k]   <= src_b[k];
                        s_q[k]   <= s_d[k];
                    end
                end
            end
        end else begin : g_single
            always_comb begin
                src_v[0] = in_valid;
                src_a[0] = a;
                src_b[0] = sub ? ~b : b;
                src_c[0] = sub ? ~cin : cin;
                src_s[0] = '0;
            end
        end
    endgenerate

    // One W_S-bit slice of the carry chain per rank.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice_c[k] = {1'b0, src_a[k][k*W_S +: W_S]} + {1'b0, src_b[k][k*W_S +: W_S]}
                       + WS1'(src_c[k]);
            s_d[k]     = src_s[k];
            s_d[k][k*W_S +: W_S] = slice_c[k][W_S-1:0];
            cy_d[k]    = slice_c[k][W_S];
        end
    end

    // Flags from the last rank; carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        raw_c     = s_d[LAST];
        msb_cin_c = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ raw_c[WIDTH-1];
        cout_d    = cy_d[LAST];
        ovf_d     = msb_cin_c ^ cy_d[LAST];
`ifdef ADDER_SAT_EN
        res_c     = !ovf_d ? raw_c :
                    src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
        res_c     = raw_c;
`endif
        zero_d    = (res_c == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (adv_c) begin
            out_vld_q <= src_v[LAST];
            sum_q     <= res_c;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
        end
    end

    assign out_valid = out_vld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
